// File: rtl/pong_state_link.sv
// Framed game-state link: serialises a field snapshot into SYNC/SEQ/payload/CHK
// byte frames for a UART transmitter and parses received frames back into fields.
module pong_state_link #(
    parameter int          NUM_FIELDS   = 6,
    parameter int          FIELD_W      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          BYTE_TIMEOUT = 65000,
    parameter int          LINK_TIMEOUT = 2_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          send_tick,
    input  logic [NUM_FIELDS*FIELD_W-1:0] tx_fields,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          tx_overrun,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [NUM_FIELDS*FIELD_W-1:0] rx_fields,
    output logic [7:0]                    rx_seq,
    output logic                          rx_update,
    output logic                          rx_error,
    output logic                          link_up
);

    localparam int FW_TOT = NUM_FIELDS * FIELD_W;
    localparam int B      = FW_TOT / 8;
    localparam int BPF    = FIELD_W / 8;
    localparam int IDX_W  = (B > 1) ? $clog2(B) : 1;
    localparam int BT_W   = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
    localparam int LT_W   = $clog2(LINK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(B - 1);
    localparam logic [BT_W-1:0]  BT_LAST  = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [LT_W-1:0]  LT_LOAD  = LT_W'(LINK_TIMEOUT);

    typedef enum logic [2:0] {TX_IDLE, TX_SYNC, TX_SEQ, TX_DATA, TX_CHK} tx_state_t;
    typedef enum logic [1:0] {RX_HUNT, RX_SEQ, RX_DATA, RX_CHK} rx_state_t;

    // Wire order: field 0 first, each field MSB byte first
    logic [7:0]        snap_bytes [B];
    logic [FW_TOT-1:0] stage_fields;
    logic [7:0]        rx_buf [B];

    always_comb begin
        stage_fields = '0;
        for (int unsigned k = 0; k < B; k++) begin
            snap_bytes[k] = tx_fields[(k / BPF) * FIELD_W + (BPF - 1 - k % BPF) * 8 +: 8];
            stage_fields[(k / BPF) * FIELD_W + (BPF - 1 - k % BPF) * 8 +: 8] = rx_buf[k];
        end
    end

    tx_state_t        tx_state, tx_state_n;
    logic [IDX_W-1:0] tx_idx, tx_idx_n;
    logic [7:0]       tx_sum, tx_sum_n, tx_seq, tx_seq_n, tx_data_n;
    logic             tx_pending, tx_pending_n, tx_overrun_n, tx_valid_n, tx_snap, tx_hs;
    logic [7:0]       tx_buf [B];

    always_comb begin
        tx_state_n   = tx_state;
        tx_idx_n     = tx_idx;
        tx_sum_n     = tx_sum;
        tx_seq_n     = tx_seq;
        tx_pending_n = tx_pending;
        tx_overrun_n = 1'b0;
        tx_snap      = 1'b0;
        tx_hs        = tx_valid && tx_ready;
        case (tx_state)
            TX_IDLE: if (send_tick) begin
                tx_snap    = 1'b1;
                tx_state_n = TX_SYNC;
            end
            TX_SYNC: if (tx_hs) tx_state_n = TX_SEQ;
            TX_SEQ: if (tx_hs) begin
                tx_state_n = TX_DATA;
                tx_idx_n   = '0;
                tx_sum_n   = tx_seq;
            end
            TX_DATA: if (tx_hs) begin
                tx_sum_n = tx_sum + tx_buf[tx_idx];
                if (tx_idx == LAST_IDX) tx_state_n = TX_CHK;
                else                    tx_idx_n   = tx_idx + 1'b1;
            end
            TX_CHK: if (tx_hs) begin
                tx_seq_n = tx_seq + 8'd1;
                if (tx_pending || send_tick) begin
                    tx_snap      = 1'b1;
                    tx_state_n   = TX_SYNC;
                    tx_pending_n = tx_pending && send_tick;
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // A tick on the final handshake was folded into the frame restart above
        if (send_tick && tx_state != TX_IDLE && !(tx_state == TX_CHK && tx_hs)) begin
            if (tx_pending) tx_overrun_n = 1'b1;
            else            tx_pending_n = 1'b1;
        end
        tx_valid_n = (tx_state_n != TX_IDLE);
        case (tx_state_n)
            TX_SYNC: tx_data_n = SYNC_BYTE;
            TX_SEQ:  tx_data_n = tx_seq_n;
            TX_DATA: tx_data_n = tx_buf[tx_idx_n];
            TX_CHK:  tx_data_n = tx_sum_n;
            default: tx_data_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state   <= TX_IDLE;
            tx_idx     <= '0;
            tx_sum     <= '0;
            tx_seq     <= '0;
            tx_pending <= 1'b0;
            tx_overrun <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            for (int unsigned k = 0; k < B; k++) tx_buf[k] <= '0;
        end else begin
            tx_state   <= tx_state_n;
            tx_idx     <= tx_idx_n;
            tx_sum     <= tx_sum_n;
            tx_seq     <= tx_seq_n;
            tx_pending <= tx_pending_n;
            tx_overrun <= tx_overrun_n;
            tx_valid   <= tx_valid_n;
            tx_data    <= tx_data_n;
            if (tx_snap)
                for (int unsigned k = 0; k < B; k++) tx_buf[k] <= snap_bytes[k];
        end
    end

    rx_state_t        rx_state, rx_state_n;
    logic [IDX_W-1:0] rx_idx, rx_idx_n;
    logic [7:0]       rx_sum, rx_sum_n, seq_stage, seq_stage_n;
    logic [BT_W-1:0]  bt_cnt, bt_cnt_n;
    logic [LT_W-1:0]  link_timer, link_timer_n;
    logic             stage_we, accept, rx_update_n, rx_error_n;

    always_comb begin
        rx_state_n  = rx_state;
        rx_idx_n    = rx_idx;
        rx_sum_n    = rx_sum;
        seq_stage_n = seq_stage;
        bt_cnt_n    = bt_cnt;
        stage_we    = 1'b0;
        accept      = 1'b0;
        rx_update_n = 1'b0;
        rx_error_n  = 1'b0;
        if (rx_state != RX_HUNT) begin
            if (rx_valid) begin
                bt_cnt_n = '0;
            end else if (bt_cnt == BT_LAST) begin
                rx_error_n = 1'b1;
                rx_state_n = RX_HUNT;
                bt_cnt_n   = '0;
            end else begin
                bt_cnt_n = bt_cnt + 1'b1;
            end
        end
        if (rx_valid) begin
            case (rx_state)
                RX_HUNT: if (rx_data == SYNC_BYTE) begin
                    rx_state_n = RX_SEQ;
                    bt_cnt_n   = '0;
                end
                RX_SEQ: begin
                    seq_stage_n = rx_data;
                    rx_sum_n    = rx_data;
                    rx_idx_n    = '0;
                    rx_state_n  = RX_DATA;
                end
                RX_DATA: begin
                    stage_we = 1'b1;
                    rx_sum_n = rx_sum + rx_data;
                    if (rx_idx == LAST_IDX) rx_state_n = RX_CHK;
                    else                    rx_idx_n   = rx_idx + 1'b1;
                end
                RX_CHK: begin
                    if (rx_data == rx_sum) begin
                        accept      = 1'b1;
                        rx_update_n = 1'b1;
                    end else begin
                        rx_error_n = 1'b1;
                    end
                    rx_state_n = RX_HUNT;
                end
                default: rx_state_n = RX_HUNT;
            endcase
        end
        if (accept)                link_timer_n = LT_LOAD;
        else if (link_timer != '0) link_timer_n = link_timer - 1'b1;
        else                       link_timer_n = link_timer;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state   <= RX_HUNT;
            rx_idx     <= '0;
            rx_sum     <= '0;
            seq_stage  <= '0;
            bt_cnt     <= '0;
            link_timer <= '0;
            link_up    <= 1'b0;
            rx_fields  <= '0;
            rx_seq     <= '0;
            rx_update  <= 1'b0;
            rx_error   <= 1'b0;
            for (int unsigned k = 0; k < B; k++) rx_buf[k] <= '0;
        end else begin
            rx_state   <= rx_state_n;
            rx_idx     <= rx_idx_n;
            rx_sum     <= rx_sum_n;
            seq_stage  <= seq_stage_n;
            bt_cnt     <= bt_cnt_n;
            link_timer <= link_timer_n;
            link_up    <= (link_timer_n != '0);
            rx_update  <= rx_update_n;
            rx_error   <= rx_error_n;
            if (stage_we) rx_buf[rx_idx] <= rx_data;
            if (accept) begin
                rx_fields <= stage_fields;
                rx_seq    <= seq_stage;
            end
        end
    end

endmodule

// File: tb/tb_pong_state_link.sv
// Randomised loopback bench for pong_state_link against a frame-level reference
// model: expected bytes are computed arithmetically from fields and sequence.
module tb_pong_state_link;

    localparam int NF = 2;
    localparam int FW = 16;
    localparam int FT = NF * FW;
    localparam int B  = FT / 8;
    localparam int BT = 40;
    localparam int LT = 500;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          send_tick = 1'b0;
    logic [FT-1:0] tx_fields = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          tx_overrun;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [FT-1:0] rx_fields;
    logic [7:0]    rx_seq;
    logic          rx_update;
    logic          rx_error;
    logic          link_up;

    logic       loop_en = 1'b1;
    logic [7:0] feed_data = '0;
    logic       feed_valid = 1'b0;

    assign rx_data  = loop_en ? tx_data : feed_data;
    assign rx_valid = loop_en ? (tx_valid && tx_ready) : feed_valid;

    pong_state_link #(
        .NUM_FIELDS  (NF),
        .FIELD_W     (FW),
        .SYNC_BYTE   (8'hA5),
        .BYTE_TIMEOUT(BT),
        .LINK_TIMEOUT(LT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .send_tick (send_tick),
        .tx_fields (tx_fields),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_overrun(tx_overrun),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_fields (rx_fields),
        .rx_seq    (rx_seq),
        .rx_update (rx_update),
        .rx_error  (rx_error),
        .link_up   (link_up)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int err_cnt = 0;
    int upd_cnt = 0;
    logic [7:0] tx_bytes [$];
    logic [7:0]    exp_seq = '0;
    logic [FT-1:0] last_fields = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: SYNC, SEQ, payload (field 0 first, MSB byte first), CHK
    function automatic logic [7:0] frame_byte(input int k, input logic [7:0] seq,
                                              input logic [FT-1:0] f);
        int bpf = FW / 8;
        int s;
        logic [FT-1:0] t;
        if (k == 0) return 8'hA5;
        if (k == 1) return seq;
        if (k <= B + 1) begin
            t = f >> ((k - 2) / bpf * FW + (bpf - 1 - (k - 2) % bpf) * 8);
            return t[7:0];
        end
        s = int'(seq);
        for (int p = 0; p < B; p++) s += int'(frame_byte(p + 2, seq, f));
        return 8'(s % 256);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (tx_valid && tx_ready) tx_bytes.push_back(tx_data);
            if (tx_overrun) ovr_cnt++;
            if (rx_error)   err_cnt++;
            if (rx_update)  upd_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [FT-1:0] f, input bit stall);
        int cyc;
        tx_bytes.delete();
        tx_fields = f;
        send_tick = 1'b1;
        tx_ready  = 1'b1;
        cyc = 0;
        do begin
            step();
            send_tick = 1'b0;
            tx_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            cyc++;
        end while (tx_bytes.size() < B + 3 && cyc < 2000);
        check("frame_done", 64'(cyc < 2000), 64'd1);
        if (!stall) check("frame_cycles", 64'(cyc), 64'(B + 4));
        for (int k = 0; k < B + 3; k++)
            if (k < tx_bytes.size())
                check("tx_byte", 64'(tx_bytes[k]), 64'(frame_byte(k, exp_seq, f)));
        @(negedge clk);
        check("rx_update", 64'(rx_update), 64'd1);
        check("rx_fields", 64'(rx_fields), 64'(f));
        check("rx_seq", 64'(rx_seq), 64'(exp_seq));
        check("link_up", 64'(link_up), 64'd1);
        check("tx_idle", 64'(tx_valid), 64'd0);
        exp_seq++;
        last_fields = f;
    endtask

    task automatic feed_bytes(input logic [55:0] v, input int n);
        logic [55:0] t;
        for (int i = 0; i < n; i++) begin
            t = v >> (8 * (n - 1 - i));
            feed_data  = t[7:0];
            feed_valid = 1'b1;
            step();
        end
        feed_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_err;
        int base_upd;
        int base_ovr;
        int n;
        logic [FT-1:0] f1;
        logic [FT-1:0] f2;

        repeat (3) step();
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_link_up", 64'(link_up), 64'd0);
        check("rst_rx_fields", 64'(rx_fields), 64'd0);
        check("rst_rx_seq", 64'(rx_seq), 64'd0);
        check("rst_rx_update", 64'(rx_update), 64'd0);
        rst = 1'b1;
        step();

        // Known frame A5 00 12 34 AB CD BE, then SEQ=01 on the next one
        send_frame(32'hABCD1234, 1'b0);
        check("first_chk_const", 64'(frame_byte(B + 2, 8'h00, 32'hABCD1234)), 64'hBE);
        send_frame(32'($urandom), 1'b1);

        base_err = err_cnt;
        for (int i = 0; i < 300; i++) begin
            send_frame(32'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) step();
        end
        check("loop_no_rx_error", 64'(err_cnt - base_err), 64'd0);

        // Three ticks under back-pressure: one in flight, one pending, one dropped
        f1 = 32'($urandom);
        f2 = 32'($urandom);
        base_upd = upd_cnt;
        base_ovr = ovr_cnt;
        tx_bytes.delete();
        tx_ready  = 1'b0;
        tx_fields = f1;
        send_tick = 1'b1; step();
        send_tick = 1'b0; tx_fields = f2; step();
        send_tick = 1'b1; step();
        send_tick = 1'b0; step();
        send_tick = 1'b1; step();
        send_tick = 1'b0;
        repeat (3) step();
        check("overrun_count", 64'(ovr_cnt - base_ovr), 64'd1);
        check("stall_valid", 64'(tx_valid), 64'd1);
        check("stall_data", 64'(tx_data), 64'hA5);
        tx_ready = 1'b1;
        repeat (2 * (B + 3) + 6) step();
        check("overrun_frames", 64'(tx_bytes.size()), 64'(2 * (B + 3)));
        for (int k = 0; k < 2 * (B + 3); k++)
            if (k < tx_bytes.size())
                check("overrun_byte", 64'(tx_bytes[k]),
                      64'(k < B + 3 ? frame_byte(k, exp_seq, f1)
                                    : frame_byte(k - (B + 3), exp_seq + 8'd1, f2)));
        check("overrun_updates", 64'(upd_cnt - base_upd), 64'd2);
        check("overrun_rx_fields", 64'(rx_fields), 64'(f2));
        check("overrun_rx_seq", 64'(rx_seq), 64'(exp_seq + 8'd1));
        exp_seq += 8'd2;
        last_fields = f2;

        // link_up stays high for exactly LINK_TIMEOUT cycles from rx_update
        send_frame(32'($urandom), 1'b0);
        n = 0;
        while (link_up && n < LT + 10) begin
            n++;
            @(negedge clk);
        end
        check("link_hold", 64'(n), 64'(LT));
        step();

        loop_en = 1'b0;
        base_err = err_cnt;
        base_upd = upd_cnt;
        feed_bytes(56'hA5_00_12_34_AB_CD_BF, 7);
        repeat (3) step();
        check("badchk_error", 64'(err_cnt - base_err), 64'd1);
        check("badchk_no_update", 64'(upd_cnt - base_upd), 64'd0);
        check("badchk_fields", 64'(rx_fields), 64'(last_fields));

        base_err = err_cnt;
        feed_bytes(56'hA5_00_12, 3);
        repeat (BT - 1) step();
        check("timeout_early", 64'(rx_error), 64'd0);
        step();
        check("timeout_pulse", 64'(rx_error), 64'd1);
        repeat (3) step();
        check("timeout_count", 64'(err_cnt - base_err), 64'd1);
        base_upd = upd_cnt;
        feed_bytes(56'hA5_00_12_34_AB_CD_BE, 7);
        repeat (2) step();
        check("after_timeout_update", 64'(upd_cnt - base_upd), 64'd1);
        check("after_timeout_fields", 64'(rx_fields), 64'hABCD1234);
        check("after_timeout_seq", 64'(rx_seq), 64'd0);

        // Reset in the middle of a stalled TX frame
        loop_en   = 1'b1;
        tx_ready  = 1'b0;
        tx_fields = 32'($urandom);
        send_tick = 1'b1; step();
        send_tick = 1'b0;
        repeat (3) step();
        check("pre_reset_valid", 64'(tx_valid), 64'd1);
        rst = 1'b0;
        step();
        check("reset_tx_valid", 64'(tx_valid), 64'd0);
        check("reset_link_up", 64'(link_up), 64'd0);
        check("reset_rx_fields", 64'(rx_fields), 64'd0);
        check("reset_rx_seq", 64'(rx_seq), 64'd0);
        rst = 1'b1;
        exp_seq = '0;
        step();
        send_frame(32'($urandom), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
